// File: rtl/shape_det_pkg.sv
// Shared types, box field layout and centre helpers for the shape detector
// and the target lock controller.
package shape_det_pkg;

  localparam int unsigned COORD_W   = 11;
  localparam int unsigned XMIN_LSB  = 0;
  localparam int unsigned YMIN_LSB  = 11;
  localparam int unsigned XMAX_LSB  = 22;
  localparam int unsigned YMAX_LSB  = 33;
  localparam int unsigned VALID_BIT = 44;
  localparam int unsigned BOX_W     = 45;
  localparam int unsigned STATE_W   = 3;
  localparam int unsigned DROP_W    = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_SEARCH  = 3'd1,
    ST_CONFIRM = 3'd2,
    ST_LOCKED  = 3'd3,
    ST_LOST    = 3'd4
  } lock_state_e;

  typedef struct packed {
    logic   lost;
    coord_t y;
    coord_t x;
  } cmd_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  // Floor of the midpoint, computed on a sum one bit wider than a coordinate.
  function automatic coord_t mid_floor(input coord_t a, input coord_t b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[COORD_W:1];
  endfunction

  function automatic coord_t mid_half_up(input coord_t a, input coord_t b);
    logic [COORD_W:0] sum;
    sum = {1'b0, a} + {1'b0, b} + (COORD_W+1)'(1);
    return sum[COORD_W:1];
  endfunction

endpackage

// File: rtl/target_lock_ctrl_if.sv
// Aim command channel: valid/ready handshake carrying the box centre and a loss flag.
interface target_lock_ctrl_if;
  import shape_det_pkg::*;

  logic   cmd_vld;
  logic   cmd_rdy;
  coord_t cmd_x;
  coord_t cmd_y;
  logic   cmd_lost;

  modport master (output cmd_vld, cmd_x, cmd_y, cmd_lost, input cmd_rdy);
  modport slave  (input cmd_vld, cmd_x, cmd_y, cmd_lost, output cmd_rdy);
endinterface

// File: rtl/box_centre_calc.sv
// Frame qualifier stage: validity/size check, box centre and jitter compare
// against the previous centre, registered once per box update.
module box_centre_calc
  import shape_det_pkg::*;
#(
  parameter int unsigned JITTER   = 8,
  parameter int unsigned MIN_SIZE = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [BOX_W-1:0] box_pos,
  input  coord_t           prev_x,
  input  coord_t           prev_y,
  output logic             ok,
  output coord_t           cx,
  output coord_t           cy,
  output logic             stable
);

  coord_t xmin, ymin, xmax, ymax, cx_c, cy_c;
  logic   ok_c, stable_c;

  // Reversed boxes are rejected explicitly so the wrapped width never qualifies.
  always_comb begin
    xmin     = box_pos[XMIN_LSB +: COORD_W];
    ymin     = box_pos[YMIN_LSB +: COORD_W];
    xmax     = box_pos[XMAX_LSB +: COORD_W];
    ymax     = box_pos[YMAX_LSB +: COORD_W];
    ok_c     = box_pos[VALID_BIT] && (xmax >= xmin) && (ymax >= ymin) &&
               ((xmax - xmin) >= COORD_W'(MIN_SIZE)) &&
               ((ymax - ymin) >= COORD_W'(MIN_SIZE));
    cx_c     = mid_floor(xmin, xmax);
    cy_c     = mid_floor(ymin, ymax);
    stable_c = (abs_diff(cx_c, prev_x) <= COORD_W'(JITTER)) &&
               (abs_diff(cy_c, prev_y) <= COORD_W'(JITTER));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ok     <= 1'b0;
      cx     <= '0;
      cy     <= '0;
      stable <= 1'b0;
    end else if (load) begin
      ok     <= ok_c;
      cx     <= cx_c;
      cy     <= cy_c;
      stable <= stable_c;
    end
  end

endmodule

// File: rtl/target_lock_ctrl.sv
// Target lock controller: confirms a target over stable frames, tracks it, reports loss.
// Build option TARGET_LOCK_AVG_EN: tracked centre is the half-up average of previous and new.
module target_lock_ctrl
  import shape_det_pkg::*;
#(
  parameter int unsigned CONFIRM_FRAMES = 4,
  parameter int unsigned LOST_FRAMES    = 10,
  parameter int unsigned JITTER         = 8,
  parameter int unsigned MIN_SIZE       = 30
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic                box_upd,
  input  logic [BOX_W-1:0]    box_pos,
  target_lock_ctrl_if.master  cmd_if,
  output logic                locked,
  output logic [STATE_W-1:0]  state,
  output logic [DROP_W-1:0]   drop_cnt
);

  localparam int unsigned STAB_W        = $clog2(CONFIRM_FRAMES + 1);
  localparam int unsigned MISS_W        = $clog2(LOST_FRAMES + 1);
  localparam bit          LOCK_ON_FIRST = (CONFIRM_FRAMES <= 1);

  lock_state_e       state_q, state_d;
  logic              upd_d1, s1_ok, s1_stable;
  coord_t            s1_cx, s1_cy, trk_x_c, trk_y_c;
  coord_t            prev_x_q, prev_y_q, prev_x_d, prev_y_d;
  logic [STAB_W-1:0] stab_q, stab_d, stab_next_c;
  logic [MISS_W-1:0] miss_q, miss_d, miss_next_c;
  logic              confirm_hit_c, miss_hit_c, issue_c, vld_q, vld_d, locked_q;
  cmd_t              cmd_q, cmd_d, issue_cmd_c;
  logic [DROP_W-1:0] drop_q, drop_d;

  box_centre_calc #(.JITTER(JITTER), .MIN_SIZE(MIN_SIZE)) u_calc (
    .clk    (clk),
    .rst    (rst),
    .load   (box_upd && enable),
    .box_pos(box_pos),
    .prev_x (prev_x_q),
    .prev_y (prev_y_q),
    .ok     (s1_ok),
    .cx     (s1_cx),
    .cy     (s1_cy),
    .stable (s1_stable)
  );

  always_comb begin
    stab_next_c   = s1_stable ? (stab_q + STAB_W'(1)) : STAB_W'(1);
    miss_next_c   = miss_q + MISS_W'(1);
    confirm_hit_c = (stab_next_c >= STAB_W'(CONFIRM_FRAMES));
    miss_hit_c    = (miss_next_c >= MISS_W'(LOST_FRAMES));
`ifdef TARGET_LOCK_AVG_EN
    trk_x_c = mid_half_up(prev_x_q, s1_cx);
    trk_y_c = mid_half_up(prev_y_q, s1_cy);
`else
    trk_x_c = s1_cx;
    trk_y_c = s1_cy;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Frame-driven transitions happen only on upd_d1; IDLE and LOST advance every cycle.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE:    state_d = ST_SEARCH;
        ST_SEARCH:  if (upd_d1 && s1_ok) state_d = LOCK_ON_FIRST ? ST_LOCKED : ST_CONFIRM;
        ST_CONFIRM: if (upd_d1) begin
                      if (!s1_ok)             state_d = ST_SEARCH;
                      else if (confirm_hit_c) state_d = ST_LOCKED;
                    end
        ST_LOCKED:  if (upd_d1 && !s1_ok && miss_hit_c) state_d = ST_LOST;
        ST_LOST:    state_d = ST_SEARCH;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    stab_d      = stab_q;
    miss_d      = miss_q;
    prev_x_d    = prev_x_q;
    prev_y_d    = prev_y_q;
    issue_c     = 1'b0;
    issue_cmd_c = '{lost: 1'b0, y: s1_cy, x: s1_cx};
    cmd_d       = cmd_q;
    drop_d      = drop_q;
    vld_d       = vld_q && !cmd_if.cmd_rdy;

    if (!enable) begin
      stab_d = '0;
      miss_d = '0;
      vld_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_SEARCH: if (upd_d1 && s1_ok) begin
          stab_d   = STAB_W'(1);
          miss_d   = '0;
          prev_x_d = s1_cx;
          prev_y_d = s1_cy;
          issue_c  = LOCK_ON_FIRST;
        end
        ST_CONFIRM: if (upd_d1) begin
          if (!s1_ok) begin
            stab_d = '0;
          end else begin
            stab_d   = stab_next_c;
            prev_x_d = s1_cx;
            prev_y_d = s1_cy;
            issue_c  = confirm_hit_c;
            miss_d   = '0;
          end
        end
        ST_LOCKED: if (upd_d1) begin
          if (s1_ok) begin
            miss_d      = '0;
            prev_x_d    = trk_x_c;
            prev_y_d    = trk_y_c;
            issue_c     = 1'b1;
            issue_cmd_c = '{lost: 1'b0, y: trk_y_c, x: trk_x_c};
          end else begin
            miss_d      = miss_next_c;
            issue_c     = miss_hit_c;
            issue_cmd_c = '{lost: 1'b1, y: prev_y_q, x: prev_x_q};
          end
        end
        default: ;
      endcase

      // Latest command wins over a pending one, except a pending loss notice.
      if (issue_c) begin
        if (vld_q && !cmd_if.cmd_rdy) begin
          drop_d = (drop_q == '1) ? drop_q : (drop_q + DROP_W'(1));
          if (!cmd_q.lost) cmd_d = issue_cmd_c;
        end else begin
          cmd_d = issue_cmd_c;
        end
        vld_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_d1   <= 1'b0;
      stab_q   <= '0;
      miss_q   <= '0;
      prev_x_q <= '0;
      prev_y_q <= '0;
      cmd_q    <= '0;
      vld_q    <= 1'b0;
      drop_q   <= '0;
      locked_q <= 1'b0;
    end else begin
      upd_d1   <= box_upd && enable;
      stab_q   <= stab_d;
      miss_q   <= miss_d;
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      cmd_q    <= cmd_d;
      vld_q    <= vld_d;
      drop_q   <= drop_d;
      locked_q <= (state_d == ST_LOCKED);
    end
  end

  assign cmd_if.cmd_vld  = vld_q;
  assign cmd_if.cmd_x    = cmd_q.x;
  assign cmd_if.cmd_y    = cmd_q.y;
  assign cmd_if.cmd_lost = cmd_q.lost;
  assign locked          = locked_q;
  assign state           = state_q;
  assign drop_cnt        = drop_q;

endmodule

// File: tb/tb_target_lock_ctrl.sv
// Bench for target_lock_ctrl: directed scenarios plus random frames against a frame-level model.
module tb_target_lock_ctrl;

`ifdef TARGET_LOCK_AVG_EN
  localparam int AVG_ON = 1;
`else
  localparam int AVG_ON = 0;
`endif
  localparam int T5_X  = AVG_ON ? 135 : 134;
  localparam int AVG_X = AVG_ON ? 135 : 140;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        box_upd;
  logic [44:0] box_pos;
  logic        locked;
  logic [2:0]  state;
  logic [7:0]  drop_cnt;

  target_lock_ctrl_if bus ();

  target_lock_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .enable  (enable),
    .box_upd (box_upd),
    .box_pos (box_pos),
    .cmd_if  (bus),
    .locked  (locked),
    .state   (state),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: mode 0 idle,1 search,2 confirm,3 locked,4 lost
  int          m_mode, m_run, m_miss, m_px, m_py;
  bit          m_have;
  logic [44:0] m_box;
  int          e_x, e_y, e_drop;
  bit          e_vld, e_lost;

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_miss = 0; m_px = 0; m_py = 0; m_have = 0; m_box = '0;
    e_x = 0; e_y = 0; e_drop = 0; e_vld = 0; e_lost = 0;
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_edge();
    int bx0, by0, bx1, by1, cx, cy, ix, iy;
    bit ok, iss, il;
    iss = 0; il = 0; ix = 0; iy = 0; ok = 0; cx = 0; cy = 0;
    if (!enable) begin
      m_mode = 0; m_run = 0; m_miss = 0; e_vld = 0; m_have = 0;
      return;
    end
    if (m_have) begin
      bx0 = int'(m_box[10:0]);  by0 = int'(m_box[21:11]);
      bx1 = int'(m_box[32:22]); by1 = int'(m_box[43:33]);
      ok  = m_box[44] && bx1 >= bx0 && by1 >= by0 && (bx1 - bx0) >= 30 && (by1 - by0) >= 30;
      cx  = (bx0 + bx1) / 2;
      cy  = (by0 + by1) / 2;
    end
    case (m_mode)
      0: m_mode = 1;
      1: if (m_have && ok) begin m_mode = 2; m_run = 1; m_px = cx; m_py = cy; end
      2: if (m_have) begin
           if (!ok) begin
             m_mode = 1; m_run = 0;
           end else begin
             m_run = (iabs(cx - m_px) <= 8 && iabs(cy - m_py) <= 8) ? m_run + 1 : 1;
             m_px = cx; m_py = cy;
             if (m_run >= 4) begin m_mode = 3; m_miss = 0; iss = 1; ix = cx; iy = cy; end
           end
         end
      3: if (m_have) begin
           if (ok) begin
             if (AVG_ON != 0) begin cx = (m_px + cx + 1) / 2; cy = (m_py + cy + 1) / 2; end
             m_miss = 0; m_px = cx; m_py = cy; iss = 1; ix = cx; iy = cy;
           end else begin
             m_miss++;
             if (m_miss >= 10) begin m_mode = 4; iss = 1; il = 1; ix = m_px; iy = m_py; end
           end
         end
      default: m_mode = 1;
    endcase
    if (iss) begin
      if (e_vld && !bus.cmd_rdy) begin
        if (e_drop < 255) e_drop++;
        if (!e_lost) begin e_x = ix; e_y = iy; e_lost = il; end
      end else begin
        e_x = ix; e_y = iy; e_lost = il;
      end
      e_vld = 1;
    end else if (e_vld && bus.cmd_rdy) begin
      e_vld = 0;
    end
    m_have = box_upd;
    m_box  = box_pos;
  endtask

  task automatic check_all();
    chk("state", 32'(state), 32'(m_mode));
    chk("locked", 32'(locked), 32'(m_mode == 3));
    chk("cmd_vld", 32'(bus.cmd_vld), 32'(e_vld));
    chk("drop_cnt", 32'(drop_cnt), 32'(e_drop));
    if (e_vld) begin
      chk("cmd_x", 32'(bus.cmd_x), 32'(e_x));
      chk("cmd_y", 32'(bus.cmd_y), 32'(e_y));
      chk("cmd_lost", 32'(bus.cmd_lost), 32'(e_lost));
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_vld"}, 32'(bus.cmd_vld), 32'(0));
    chk({tag, "_x"}, 32'(bus.cmd_x), 32'(0));
    chk({tag, "_y"}, 32'(bus.cmd_y), 32'(0));
    chk({tag, "_lost"}, 32'(bus.cmd_lost), 32'(0));
    chk({tag, "_locked"}, 32'(locked), 32'(0));
    chk({tag, "_state"}, 32'(state), 32'(0));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(0));
  endtask

  // Called at a falling edge; advances one clock and compares on the next falling edge.
  task automatic step();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_box(input int x0, input int x1, input int y0, input int y1, input bit v);
    box_pos = {v, 11'(y1), 11'(x1), 11'(y0), 11'(x0)};
  endtask

  // Returns two clocks after the box_upd pulse, when the resulting command is visible.
  task automatic send_box(input int x0, input int x1, input int y0, input int y1, input bit v);
    set_box(x0, x1, y0, y1, v);
    box_upd = 1'b1;
    step();
    box_upd = 1'b0;
    step();
  endtask

  initial begin
    int tx, ty, w, h, x0, x1, y0, y1, c, gap;
    bit v, lossy;
    enable = 0; box_upd = 0; box_pos = '0; bus.cmd_rdy = 0; rst = 0;
    #1 rst = 1;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 0;
    enable = 1; bus.cmd_rdy = 1;
    step();

    // T1: four stable frames 100 clk apart; lock on the fourth, two clocks after box_upd
    for (int i = 1; i <= 4; i++) begin
      set_box(100, 160, 200, 260, 1'b1);
      box_upd = 1'b1;
      step();
      chk("t1_lat1", 32'(bus.cmd_vld), 32'(0));
      box_upd = 1'b0;
      step();
      chk("t1_vld", 32'(bus.cmd_vld), 32'(i == 4));
      if (i == 4) begin
        chk("t1_x", 32'(bus.cmd_x), 32'(130));
        chk("t1_y", 32'(bus.cmd_y), 32'(230));
        chk("t1_locked", 32'(locked), 32'(1));
      end
      idle(98);
    end

    // T2: ten invalid frames in LOCKED produce a loss notice
    for (int i = 0; i < 9; i++) begin send_box(100, 160, 200, 260, 1'b0); idle(3); end
    send_box(100, 160, 200, 260, 1'b0);
    chk("t2_lost", 32'(bus.cmd_lost), 32'(1));
    chk("t2_vld", 32'(bus.cmd_vld), 32'(1));
    chk("t2_x", 32'(bus.cmd_x), 32'(130));
    chk("t2_y", 32'(bus.cmd_y), 32'(230));
    step();
    chk("t2_search", 32'(state), 32'(1));
    idle(2);

    // T3: centre jumps +20 on frame 3; lock only on frame 6
    send_box(100, 160, 200, 260, 1'b1); idle(2);
    send_box(100, 160, 200, 260, 1'b1); idle(2);
    for (int i = 3; i <= 6; i++) begin
      send_box(120, 180, 200, 260, 1'b1);
      chk("t3_locked", 32'(locked), 32'(i == 6));
      idle(2);
    end

    // T5: backpressure across three frames; latest centre kept, two drops, one accept
    bus.cmd_rdy = 0;
    send_box(100, 160, 200, 260, 1'b1); idle(2);
    send_box(102, 162, 200, 260, 1'b1); idle(2);
    send_box(104, 164, 200, 260, 1'b1);
    chk("t5_drop", 32'(drop_cnt), 32'(2));
    chk("t5_vld", 32'(bus.cmd_vld), 32'(1));
    chk("t5_x", 32'(bus.cmd_x), 32'(T5_X));
    bus.cmd_rdy = 1;
    step();
    chk("t5_accept", 32'(bus.cmd_vld), 32'(0));
    idle(2);

    enable = 0;
    step();
    chk("dis_state", 32'(state), 32'(0));
    enable = 1;
    step();

    // T4: undersized boxes never leave SEARCH
    for (int i = 0; i < 5; i++) begin
      send_box(120, 140, 220, 240, 1'b1);
      chk("t4_state", 32'(state), 32'(1));
      chk("t4_vld", 32'(bus.cmd_vld), 32'(0));
      idle(2);
    end

    // Boundaries: width 29 rejected, width 30 with steps of exactly JITTER locks
    send_box(115, 144, 215, 245, 1'b1);
    chk("b_w29", 32'(state), 32'(1));
    idle(2);
    for (int i = 0; i < 4; i++) begin
      c = 130 + 8 * i;
      send_box(c - 15, c + 15, 215, 245, 1'b1);
      chk("b_lock", 32'(locked), 32'(i == 3));
      idle(2);
    end

    // T6: asynchronous reset while LOCKED with a pending command
    bus.cmd_rdy = 0;
    send_box(100, 160, 200, 260, 1'b1);
    chk("t6_pend", 32'(bus.cmd_vld), 32'(1));
    #2 rst = 1;
    #1 check_reset("t6");
    model_reset();
    @(negedge clk);
    rst = 0; bus.cmd_rdy = 1;
    step();

    // Averaging: lock at 130 then a frame centred at 140
    for (int i = 0; i < 4; i++) begin send_box(100, 160, 200, 260, 1'b1); idle(2); end
    send_box(110, 170, 200, 260, 1'b1);
    chk("avg_x", 32'(bus.cmd_x), 32'(AVG_X));
    idle(2);

    // Random frames: jitter, undersized/reversed boxes, lossy bursts, backpressure, enable drops
    tx = 1000; ty = 1000; lossy = 0;
    for (int f = 0; f < 300; f++) begin
      if (f % 20 == 0) begin
        lossy = ($urandom_range(0, 2) == 0);
        tx = int'($urandom_range(200, 1800));
        ty = int'($urandom_range(200, 1800));
      end
      w  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 35)) : int'($urandom_range(30, 200));
      h  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 35)) : int'($urandom_range(30, 200));
      x0 = tx + int'($urandom_range(0, 22)) - 11 - w / 2; x1 = x0 + w;
      y0 = ty + int'($urandom_range(0, 22)) - 11 - h / 2; y1 = y0 + h;
      if ($urandom_range(0, 29) == 0) begin c = x0; x0 = x1; x1 = c; end
      v = lossy ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 19) != 0);
      set_box(x0, x1, y0, y1, v);
      box_upd = 1'b1;
      enable = ($urandom_range(0, 99) >= 2);
      bus.cmd_rdy = ($urandom_range(0, 9) < 7);
      step();
      box_upd = 1'b0;
      gap = int'($urandom_range(1, 4));
      for (int g = 0; g < gap; g++) begin
        enable = ($urandom_range(0, 99) >= 2);
        bus.cmd_rdy = ($urandom_range(0, 9) < 7);
        step();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
